// File: rtl/mau_pkg.sv
// Shared op encodings, FSM state enum and small op-classification helpers
// for the memory access unit.
package mau_pkg;

  typedef enum logic [3:0] {
    OP_LW   = 4'd0,
    OP_LH   = 4'd1,
    OP_LHU  = 4'd2,
    OP_LB   = 4'd3,
    OP_LBU  = 4'd4,
    OP_LWRR = 4'd5,
    OP_SW   = 4'd6,
    OP_SH   = 4'd7,
    OP_SB   = 4'd8
  } mau_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_RESP = 2'd2
  } mau_state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= OP_SB;
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Combinational load result formatting: extracts and extends the addressed
// byte/halfword, or rotates the whole word for LWRR.
module load_formatter
  import mau_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [3:0]        op,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] word,
  output logic [DATA_W-1:0] result
);

  logic [2*DATA_W-1:0] dbl;
  logic [DATA_W-1:0]   rot;

  always_comb begin
    // Rotating right by 8*off puts the addressed byte/halfword in the low lanes.
    dbl    = {word, word} >> {off, 3'b000};
    rot    = dbl[DATA_W-1:0];
    result = '0;
    case (op)
      OP_LW:   result = word;
      OP_LH:   result = {{(DATA_W-16){rot[15]}}, rot[15:0]};
      OP_LHU:  result = {{(DATA_W-16){1'b0}}, rot[15:0]};
      OP_LB:   result = {{(DATA_W-8){rot[7]}}, rot[7:0]};
      OP_LBU:  result = {{(DATA_W-8){1'b0}}, rot[7:0]};
      OP_LWRR: result = rot;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store unit: IDLE accepts a request, MEM holds a
// memory access until ack or timeout, RESP holds the result until taken.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [4:0]          req_rd,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic [4:0]          resp_rd,
  output logic                resp_wen,
  output logic                resp_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  mau_state_e          state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [4:0]          rd_q, rd_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                err_q, err_d;
  logic                wen_q, wen_d;

  logic [OFF_W-1:0]    off_in;
  logic                misaligned;
  logic [BE_W-1:0]     be_in;
  logic [DATA_W-1:0]   wdata_in;
  logic [DATA_W-1:0]   fmt;
  logic                in_mem, in_resp;

  assign off_in = req_addr[OFF_W-1:0];

  always_comb begin
    misaligned = 1'b0;
    be_in      = '1;
    wdata_in   = req_wdata;
    case (req_op)
      OP_LW, OP_SW:          misaligned = |off_in;
      OP_LH, OP_LHU, OP_SH:  misaligned = off_in[0];
      default:               misaligned = 1'b0;
    endcase
    case (req_op)
      OP_SH: begin
        be_in    = BE_W'(2'b11) << off_in;
        wdata_in = {(DATA_W/16){req_wdata[15:0]}};
      end
      OP_SB: begin
        be_in    = BE_W'(1'b1) << off_in;
        wdata_in = {(DATA_W/8){req_wdata[7:0]}};
      end
      default: ;
    endcase
  end

  load_formatter #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_fmt (
    .op     (op_q),
    .off    (addr_q[OFF_W-1:0]),
    .word   (mem_rdata),
    .result (fmt)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    wen_d   = wen_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          addr_d  = req_addr;
          rd_d    = req_rd;
          be_d    = be_in;
          wdata_d = wdata_in;
          cnt_d   = '0;
          data_d  = '0;
          wen_d   = 1'b0;
          // Illegal requests skip memory and report straight away.
          if (op_is_legal(req_op) && !misaligned) begin
            state_d = ST_MEM;
            err_d   = 1'b0;
          end else begin
            state_d = ST_RESP;
            err_d   = 1'b1;
          end
        end
      end
      ST_MEM: begin
        // Ack is checked first so an ack on the final allowed cycle still succeeds.
        if (mem_ack) begin
          data_d  = op_is_store(op_q) ? '0 : fmt;
          wen_d   = !op_is_store(op_q);
          state_d = ST_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      rd_q    <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
      wen_q   <= wen_d;
    end
  end

  assign in_mem  = (state_q == ST_MEM);
  assign in_resp = (state_q == ST_RESP);

  assign req_ready  = (state_q == ST_IDLE);
  assign mem_req    = in_mem;
  assign mem_we     = in_mem && op_is_store(op_q);
  assign mem_addr   = in_mem ? {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_be     = in_mem ? be_q : '0;
  assign mem_wdata  = in_mem ? wdata_q : '0;
  assign resp_valid = in_resp;
  assign resp_data  = in_resp ? data_q : '0;
  assign resp_rd    = in_resp ? rd_q : '0;
  assign resp_wen   = in_resp && wen_q;
  assign resp_err   = in_resp && err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a transaction-level timeline model
// predicts every output each cycle; directed cases pin known answers.
module tb_mem_access_unit;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        resp_valid, resp_ready, resp_wen, resp_err;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_rd(resp_rd), .resp_wen(resp_wen), .resp_err(resp_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected output picture for the current cycle
  logic        e_req_ready, e_mem_req, e_resp_valid;
  logic        e_we, e_wen, e_err;
  logic [31:0] e_addr, e_wdata, e_data;
  logic [3:0]  e_be;
  logic [4:0]  e_rd;
  bit          cmp_en = 1'b0;

  logic [31:0] last_data, last_wdata;
  logic        last_err, last_wen, last_we;
  logic [3:0]  last_be;
  bit          saw_mem;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_ready", 32'(req_ready), 32'(e_req_ready));
      chk("mem_req", 32'(mem_req), 32'(e_mem_req));
      chk("resp_valid", 32'(resp_valid), 32'(e_resp_valid));
      if (mem_req) saw_mem = 1'b1;
      if (e_mem_req) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_be", 32'(mem_be), 32'(e_be));
        chk("mem_wdata", mem_wdata, e_wdata);
        last_be = mem_be; last_wdata = mem_wdata; last_we = mem_we;
      end
      if (e_resp_valid) begin
        chk("resp_data", resp_data, e_data);
        chk("resp_rd", 32'(resp_rd), 32'(e_rd));
        chk("resp_wen", 32'(resp_wen), 32'(e_wen));
        chk("resp_err", 32'(resp_err), 32'(e_err));
        last_data = resp_data; last_err = resp_err; last_wen = resp_wen;
      end
    end
  end

  // ---------------- behavioural model ----------------
  function automatic bit m_store(input int op);
    return op >= 6 && op <= 8;
  endfunction

  function automatic bit m_legal(input int op, input logic [31:0] a);
    int off = int'(a[1:0]);
    if (op > 8) return 1'b0;
    if ((op == 0 || op == 6) && off != 0) return 1'b0;
    if ((op == 1 || op == 2 || op == 7) && (off % 2) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] m_be(input int op, input int off);
    if (op == 7) return 4'b0011 << off;
    if (op == 8) return 4'b0001 << off;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input int op, input logic [31:0] w);
    if (op == 7) return {2{w[15:0]}};
    if (op == 8) return {4{w[7:0]}};
    return w;
  endfunction

  function automatic logic [31:0] m_load(input int op, input int off, input logic [31:0] w);
    logic [31:0] sh;
    logic [31:0] rr;
    sh = w >> (8 * off);
    rr = (off == 0) ? w : ((w >> (8 * off)) | (w << (32 - 8 * off)));
    case (op)
      0: return w;
      1: return {{16{sh[15]}}, sh[15:0]};
      2: return {16'h0, sh[15:0]};
      3: return {{24{sh[7]}}, sh[7:0]};
      4: return {24'h0, sh[7:0]};
      5: return rr;
      default: return 32'h0;
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    e_req_ready = 1'b1; e_mem_req = 1'b0; e_resp_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_be"}, 32'(mem_be), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_data"}, resp_data, 32'd0);
    chk({tag, "_resp_rd"}, 32'(resp_rd), 32'd0);
    chk({tag, "_resp_wen"}, 32'(resp_wen), 32'd0);
    chk({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // lat: MEM cycles without ack before the ack cycle (-1 = never ack)
  task automatic run_txn(input int op, input logic [31:0] a, input logic [31:0] wd,
                         input logic [4:0] rd, input logic [31:0] rdv,
                         input int lat, input int rhold);
    bit legal = m_legal(op, a);
    bit timed = 1'b0;
    saw_mem   = 1'b0;
    req_valid = 1'b1; req_op = 4'(op); req_addr = a; req_wdata = wd; req_rd = rd;
    tick();
    req_valid = 1'b0; req_op = 4'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_rd = 5'($urandom);
    e_req_ready = 1'b0;
    if (legal) begin
      e_mem_req = 1'b1; e_we = m_store(op); e_addr = {a[31:2], 2'b00};
      e_be = m_be(op, int'(a[1:0])); e_wdata = m_wdata(op, wd);
      for (int k = 1; k <= TO; k++) begin
        mem_ack   = (k == lat + 1);
        mem_rdata = mem_ack ? rdv : $urandom;
        tick();
        if (k == lat + 1) break;
        if (k == TO) timed = 1'b1;
      end
      mem_ack = 1'b0; e_mem_req = 1'b0;
    end
    e_resp_valid = 1'b1; e_rd = rd;
    if (!legal || timed) begin
      e_err = 1'b1; e_data = 32'h0; e_wen = 1'b0;
    end else if (m_store(op)) begin
      e_err = 1'b0; e_data = 32'h0; e_wen = 1'b0;
    end else begin
      e_err = 1'b0; e_data = m_load(op, int'(a[1:0]), rdv); e_wen = 1'b1;
    end
    // A legal request is offered during the response; it must not be taken
    // before the response retires.
    req_valid = 1'b1; req_op = 4'd0; req_addr = $urandom & 32'hFFFF_FFFC;
    resp_ready = 1'b0;
    repeat (rhold) tick();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0; req_valid = 1'b0;
    set_idle();
  endtask

  task automatic reset_mid(input bit during_resp);
    req_valid = 1'b1; req_op = 4'd0; req_addr = 32'h100; req_wdata = 32'h0; req_rd = 5'd3;
    tick();
    req_valid = 1'b0; e_req_ready = 1'b0;
    e_mem_req = 1'b1; e_we = 1'b0; e_addr = 32'h100; e_be = 4'hF; e_wdata = 32'h0;
    if (during_resp) begin
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      tick();
      mem_ack = 1'b0; e_mem_req = 1'b0;
      e_resp_valid = 1'b1; e_data = 32'hCAFE_F00D; e_rd = 5'd3; e_wen = 1'b1; e_err = 1'b0;
      tick();
    end else begin
      repeat (3) tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    set_idle();
    check_zero(during_resp ? "rst_resp" : "rst_mem");
  endtask

  initial begin
    req_valid = 1'b0; req_op = 4'd0; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'h0; resp_ready = 1'b0;
    reset = 1'b0;
    set_idle();
    tick();
    cmp_en = 1'b1;
    check_zero("reset");
    reset = 1'b1;
    tick();

    run_txn(5, 32'h1002, 32'h0, 5'd7, 32'h1122_3344, 0, 0);
    chk("lwrr_data", last_data, 32'h3344_1122);
    chk("lwrr_wen", 32'(last_wen), 32'd1);
    run_txn(3, 32'h3, 32'h0, 5'd1, 32'h80FF_FFFF, 1, 1);
    chk("lb_data", last_data, 32'hFFFF_FF80);
    run_txn(4, 32'h3, 32'h0, 5'd2, 32'h80FF_FFFF, 0, 0);
    chk("lbu_data", last_data, 32'h0000_0080);
    run_txn(8, 32'h2, 32'hAB, 5'd4, 32'h0, 0, 2);
    chk("sb_be", 32'(last_be), 32'h4);
    chk("sb_wdata", last_wdata, 32'hABAB_ABAB);
    chk("sb_we", 32'(last_we), 32'd1);
    chk("sb_wen", 32'(last_wen), 32'd0);
    run_txn(0, 32'h2, 32'h0, 5'd5, 32'h0, 0, 0);
    chk("lw_mis_err", 32'(last_err), 32'd1);
    chk("lw_mis_data", last_data, 32'h0);
    chk("lw_mis_nomem", 32'(saw_mem), 32'd0);
    run_txn(12, 32'h0, 32'h0, 5'd6, 32'h0, 0, 0);
    chk("illegal_op_err", 32'(last_err), 32'd1);
    run_txn(0, 32'h40, 32'h0, 5'd8, 32'h0, -1, 0);
    chk("timeout_err", 32'(last_err), 32'd1);
    run_txn(0, 32'h44, 32'h0, 5'd9, 32'h5A5A_1234, TO - 1, 0);
    chk("late_ack_err", 32'(last_err), 32'd0);
    chk("late_ack_data", last_data, 32'h5A5A_1234);
    run_txn(1, 32'h6, 32'h0, 5'd10, 32'h8001_7FFF, 2, 5);
    chk("lh_hold_data", last_data, 32'hFFFF_8001);
    reset_mid(1'b0);
    reset_mid(1'b1);

    for (int i = 0; i < 300; i++) begin
      int op;
      op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      run_txn(op, $urandom, $urandom, 5'($urandom), $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, 32, data width in bits; SHALL be a power of two and at least 16.
REQ-002 Parameter ADDR_W, 32, byte-address width.
REQ-003 Parameter TIMEOUT, 255, maximum cycles spent waiting for mem_ack.
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset  in  1  synchronous, active-low reset.
REQ-006 req_valid  in  1  request offered.
REQ-007 req_ready  out  1  unit can accept a request.
REQ-008 req_op  in  4  0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU, 5 LWRR, 6 SW, 7 SH, 8 SB; 9-15 illegal.
REQ-009 req_addr  in  ADDR_W  byte address.
REQ-010 req_wdata  in  DATA_W  store data, right-aligned.
REQ-011 req_rd  in  5  destination register tag for loads.
REQ-012 mem_req  out  1  memory access request, held until mem_ack.
REQ-013 mem_we  out  1  memory access is a write.
REQ-014 mem_addr  out  ADDR_W  word-aligned address (offset bits forced to 0).
REQ-015 mem_be  out  DATA_W/8  byte enables.
REQ-016 mem_wdata  out  DATA_W  lane-positioned store data.
REQ-017 mem_ack  in  1  memory completes the access.
REQ-018 mem_rdata  in  DATA_W  read word; valid only in the mem_ack cycle.
REQ-019 resp_valid  out  1  response available.
REQ-020 resp_ready  in  1  consumer takes the response.
REQ-021 resp_data  out  DATA_W  formatted load result; 0 for stores and errors.
REQ-022 resp_rd  out  5  copy of the latched req_rd.
REQ-023 resp_wen  out  1  register write required (successful load only).
REQ-024 resp_err  out  1  misaligned access, illegal op or timeout.

Function
REQ-025 FSM SHALL have states IDLE, MEM and RESP; req_ready SHALL be 1 only in IDLE.
REQ-026 In IDLE, req_valid=1 SHALL latch op, addr, wdata and rd; the next state SHALL be MEM if the request is legal, or RESP with err=1 otherwise (no memory access).
REQ-027 Alignment rules, with off = addr[log2(DATA_W/8)-1:0]:
  - LW and SW require off=0.
  - LH, LHU and SH require off[0]=0.
  - Byte operations and LWRR are never misaligned.
REQ-028 In MEM, mem_req SHALL be 1, and mem_addr, mem_we, mem_be and mem_wdata SHALL be held stable until the cycle mem_ack=1; the next state is RESP.
REQ-029 Byte enables: SW all ones; SH 2'b11<<off; SB 1<<off; all loads all ones.
REQ-030 Store data: SH replicates req_wdata[15:0] into every halfword; SB replicates req_wdata[7:0] into every byte.
REQ-031 Load formatting, registered at mem_ack:
  - LW: the word unchanged.
  - LH/LHU: halfword at off, sign- or zero-extended.
  - LB/LBU: byte at off, sign- or zero-extended.
  - LWRR: the word rotated right by 8*off bits.
REQ-032 A timeout counter SHALL clear on entry to MEM and increment each MEM cycle without ack; on reaching TIMEOUT the FSM SHALL go to RESP with err=1 and mem_req SHALL drop.
REQ-033 If mem_ack arrives in the same cycle the counter reaches TIMEOUT, ack wins (no error).
REQ-034 In RESP, resp_valid=1 and all resp_* outputs SHALL be held stable until resp_ready=1; the next state is IDLE.
REQ-035 A new request SHALL NOT be accepted in the same cycle a response retires.
REQ-036 Latency with mem_ack in the first MEM cycle: accept at cycle 0, mem_req at cycle 1, resp_valid at cycle 2.

Reset
REQ-037 reset=0 at a clock edge SHALL force IDLE and clear the counter and all latched fields, including mid-MEM and mid-RESP; any outstanding memory access is abandoned.
REQ-038 Reset values: req_ready=1; every other output 0.

Structure
REQ-039 The op encodings and FSM state enum SHALL live in the shared package mau_pkg.
REQ-040 Load formatting SHALL be one combinational sub-module, load_formatter (inputs: op, off, word; output: result).

Verification
REQ-041 LWRR, addr 0x1002, mem_rdata 0x11223344, ack in the first cycle -> resp_data 0x33441122, resp_wen=1, resp_valid at cycle 2.
REQ-042 LB at addr 0x3, rdata 0x80FFFFFF -> 0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-043 SB at addr 0x2 with wdata 0xAB -> mem_be 4'b0100, mem_wdata 0xABABABAB, mem_we=1, resp_wen=0.
REQ-044 LW at addr 0x2 -> no mem_req, resp_err=1, resp_data 0; op 12 -> resp_err=1.
REQ-045 No mem_ack for 255 MEM cycles -> resp_err=1, mem_req drops; with ack on cycle 255 instead -> resp_err=0.
REQ-046 resp_ready held 0 for 5 cycles -> resp_* stable and req_ready=0; reset=0 asserted during MEM -> IDLE next cycle, mem_req=0.
